// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue. Holds {pc, instr} pairs in a small circular
// FIFO, presents the oldest entry to decode, and stalls the PC register when full.
// A flush (redirect) or reset empties the queue and discards the incoming fetch.
module fetch_queue #(
  parameter int unsigned    DEPTH = 2,
  parameter int unsigned    XLEN  = 32,
  parameter logic [XLEN-1:0] NOP  = XLEN'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_f,
  input  logic [XLEN-1:0]            pcf,
  input  logic [XLEN-1:0]            instr_f,
  output logic                       stall_f,
  input  logic                       stall_d,
  input  logic                       flush,
  output logic                       valid_d,
  output logic [XLEN-1:0]            instr_d,
  output logic [XLEN-1:0]            pc_d,
  output logic [XLEN-1:0]            pc_plus4_d,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry storage; deliberately not reset, occupancy alone defines validity.
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q,  count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Occupancy flags and handshake qualification.
  always_comb begin
    full  = (count_q == CntW'(DEPTH));
    empty = (count_q == '0);
    // A full queue never accepts, even if it drains this cycle: no pass-through.
    push  = valid_f & ~full  & ~flush;
    pop   = ~empty  & ~stall_d & ~flush;
  end

  // Next-state pointers and occupancy; reset takes priority over flush.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointer widths equal log2(DEPTH), so natural overflow is the mod-DEPTH wrap.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset folded into next-state.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Entry write on accepted fetch.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem_q[wr_ptr_q]    <= pcf;
      instr_mem_q[wr_ptr_q] <= instr_f;
    end
  end

  // Decode-side view of the head entry, with NOP/zero substitutes when empty.
  always_comb begin
    valid_d    = ~empty;
    stall_f    = full;
    count      = count_q;
    pc_d       = '0;
    instr_d    = NOP;
    if (!empty) begin
      pc_d    = pc_mem_q[rd_ptr_q];
      instr_d = instr_mem_q[rd_ptr_q];
    end
    pc_plus4_d = pc_d + XLEN'(4);
  end

endmodule
